// File: rtl/bf16_fma_pipe.sv
// Three-stage bf16 fused multiply-add pipeline with valid/ready handshake.
// Add/sub run as a*1.0 +/- b so every opcode shares the fused datapath.
module bf16_fma_pipe (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] operand_a,
    input  logic [15:0] operand_b,
    input  logic [15:0] operand_c,
    input  logic [3:0]  operation,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic [3:0]  fpcsr
);
    localparam logic signed [10:0] ZERO_EXP = -11'sd512;

    // Returns {zero_or_subnormal, inf, nan, snan}.
    function automatic logic [3:0] classify(input logic [14:0] v);
        logic emax;
        emax = &v[14:7];
        return {v[14:7] == 8'h00, emax && v[6:0] == 7'h00,
                emax && v[6:0] != 7'h00, emax && v[6:0] != 7'h00 && !v[6]};
    endfunction

    // m carries the leading bit of the larger addend at bit 24; returns {flags, bf16}.
    function automatic logic [19:0] round_pack(input logic sgn, input logic signed [10:0] e,
                                               input logic [25:0] m);
        logic [4:0]         k;
        logic [25:0]        n;
        logic [7:0]         r;
        logic               g, st, up;
        logic signed [10:0] re;
        k = 5'd0;
        for (int i = 0; i < 26; i++)
            if (m[i]) k = 5'(i);
        n  = m << (5'd25 - k);
        g  = n[17];
        st = |n[16:0];
        up = g & (n[18] | st);
        r  = {1'b0, n[24:18]} + {7'b0, up};
        re = e + $signed({6'b0, k}) - 11'sd24 + $signed({10'b0, r[7]});
        if (!n[25]) return {4'b0000, sgn, 15'h0000};
        if (re > 11'sd254) return {4'b0101, sgn, 15'h7F80};
        if (re < 11'sd1) return {4'b0011, sgn, 15'h0000};
        return {3'b000, g | st, sgn, re[7:0], r[6:0]};
    endfunction

    logic en;
    logic vld_p0, vld_p1, vld_p2;
    assign en       = !vld_p2 || out_ready;
    assign in_ready = en;

    // ---- S1: operand mapping, unpack, classify, multiply ----
    logic [15:0] x, y, z;
    logic        bad_op;
    always_comb begin
        x      = operand_a;
        y      = operand_b;
        z      = operand_c;
        bad_op = 1'b0;
        case (operation)
            4'h0: begin y = 16'h3F80; z = operand_b; end
            4'h1: begin y = 16'h3F80; z = operand_b ^ 16'h8000; end
            4'h2: z = {operand_a[15] ^ operand_b[15], 15'h0000};
            4'h7: z = operand_c;
            4'h8: z = operand_c ^ 16'h8000;
            default: bad_op = 1'b1;
        endcase
    end

    logic [3:0]         cx, cy, cz;
    logic [15:0]        prod, sigp_s1, sigz_s1;
    logic signed [10:0] ep_s1, ez_s1;
    logic               sp_s1, p_zero, p_inf, spec_s1;
    logic [15:0]        spres_s1;
    logic [3:0]         spflg_s1;
    assign cx      = classify(x[14:0]);
    assign cy      = classify(y[14:0]);
    assign cz      = classify(z[14:0]);
    assign prod    = {1'b1, x[6:0]} * {1'b1, y[6:0]};
    assign sp_s1   = x[15] ^ y[15];
    assign p_zero  = cx[3] | cy[3];
    assign p_inf   = cx[2] | cy[2];
    assign sigp_s1 = p_zero ? 16'h0000 : (prod[15] ? prod : {prod[14:0], 1'b0});
    assign ep_s1   = p_zero ? ZERO_EXP : $signed({3'b0, x[14:7]}) + $signed({3'b0, y[14:7]})
                                         - 11'sd127 + $signed({10'b0, prod[15]});
    assign sigz_s1 = cz[3] ? 16'h0000 : {1'b1, z[6:0], 8'h00};
    assign ez_s1   = cz[3] ? ZERO_EXP : $signed({3'b0, z[14:7]});

    always_comb begin
        spec_s1  = 1'b1;
        spres_s1 = 16'h7FC0;
        spflg_s1 = 4'b1000;
        if (bad_op) begin
            spflg_s1 = 4'b1000;
        end else if (cx[1] | cy[1] | cz[1]) begin
            spflg_s1 = {cx[0] | cy[0] | cz[0] | (p_inf & p_zero), 3'b000};
        end else if ((p_inf & p_zero) || (p_inf && cz[2] && sp_s1 != z[15])) begin
            spflg_s1 = 4'b1000;
        end else if (p_inf) begin
            spres_s1 = {sp_s1, 15'h7F80};
            spflg_s1 = 4'b0000;
        end else if (cz[2]) begin
            spres_s1 = {z[15], 15'h7F80};
            spflg_s1 = 4'b0000;
        end else begin
            spec_s1  = 1'b0;
        end
    end

    logic [15:0]        sigp_p0, sigz_p0, spres_p0;
    logic signed [10:0] ep_p0, ez_p0;
    logic               sp_p0, sz_p0, spec_p0;
    logic [3:0]         spflg_p0;

    // ---- S2: align the smaller addend with jammed sticky, add/subtract ----
    logic               p_big, eff_sub, sticky, sgn_s2;
    logic signed [10:0] e_big, d;
    logic [15:0]        sig_big, sig_sml;
    logic [4:0]         dc;
    logic [47:0]        sh;
    logic [25:0]        sum;
    always_comb begin
        p_big   = (ep_p0 > ez_p0) || ((ep_p0 == ez_p0) && (sigp_p0 >= sigz_p0));
        e_big   = p_big ? ep_p0 : ez_p0;
        d       = p_big ? ep_p0 - ez_p0 : ez_p0 - ep_p0;
        sig_big = p_big ? sigp_p0 : sigz_p0;
        sig_sml = p_big ? sigz_p0 : sigp_p0;
        dc      = (d > 11'sd31) ? 5'd31 : d[4:0];
        sh      = {sig_sml, 32'h0} >> dc;
        sticky  = |sh[23:0];
        eff_sub = sp_p0 ^ sz_p0;
        sum     = eff_sub ? {1'b0, sig_big, 9'h000} - {1'b0, sh[47:24], sticky}
                          : {1'b0, sig_big, 9'h000} + {1'b0, sh[47:24], sticky};
        // An exact zero is -0 only when both addends are negative.
        sgn_s2  = (sum == 26'h0) ? (sp_p0 & sz_p0) : (p_big ? sp_p0 : sz_p0);
    end

    logic [25:0]        sum_p1;
    logic signed [10:0] e_p1;
    logic               sgn_p1, spec_p1;
    logic [15:0]        spres_p1;
    logic [3:0]         spflg_p1;

    // ---- S3: normalize, round, pack ----
    logic [19:0] packed_s3;
    assign packed_s3 = round_pack(sgn_p1, e_p1, sum_p1);

    logic [15:0] res_p2;
    logic [3:0]  flg_p2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (en) begin
            vld_p0 <= in_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            sigp_p0  <= sigp_s1;
            sigz_p0  <= sigz_s1;
            ep_p0    <= ep_s1;
            ez_p0    <= ez_s1;
            sp_p0    <= sp_s1;
            sz_p0    <= z[15];
            spec_p0  <= spec_s1;
            spres_p0 <= spres_s1;
            spflg_p0 <= spflg_s1;
            sum_p1   <= sum;
            e_p1     <= e_big;
            sgn_p1   <= sgn_s2;
            spec_p1  <= spec_p0;
            spres_p1 <= spres_p0;
            spflg_p1 <= spflg_p0;
            res_p2   <= spec_p1 ? spres_p1 : packed_s3[15:0];
            flg_p2   <= spec_p1 ? spflg_p1 : packed_s3[19:16];
        end
    end

    assign out_valid = vld_p2;
    assign result    = vld_p2 ? res_p2 : 16'h0000;
    assign fpcsr     = vld_p2 ? flg_p2 : 4'h0;
endmodule

// File: tb/tb_bf16_fma_pipe.sv
// Directed bench for bf16_fma_pipe: arithmetic vectors, latency, streaming,
// backpressure and mid-flight reset.
module tb_bf16_fma_pipe;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] operand_a, operand_b, operand_c;
    logic [3:0]  operation;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  fpcsr;

    int checks = 0;
    int errors = 0;

    bf16_fma_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .operand_a(operand_a), .operand_b(operand_b), .operand_c(operand_c),
        .operation(operation), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .fpcsr(fpcsr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed time beyond budget, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c);
        operation = op;
        operand_a = a;
        operand_b = b;
        operand_c = c;
        in_valid  = 1'b1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        operation = 4'($urandom);
        operand_a = 16'($urandom);
        operand_b = 16'($urandom);
        operand_c = 16'($urandom);
    endtask

    // Issue one request now, expect its result in the third cycle after issue.
    task automatic run_one(input string tag, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] c,
                           input logic [15:0] er, input logic [3:0] ef);
        int lat;
        drive(op, a, b, c);
        @(negedge clk);
        idle_inputs();
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, 3);
        chk({tag, " result"}, result, er);
        chk({tag, " fpcsr"}, fpcsr, ef);
        @(negedge clk);
    endtask

    logic [15:0] bp_exp [4];
    int          got;

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        operation = 4'h0;
        operand_a = 16'h0;
        operand_b = 16'h0;
        operand_c = 16'h0;
        #1 reset  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset out_valid", out_valid, 0);
        chk("reset result", result, 16'h0000);
        chk("reset fpcsr", fpcsr, 4'h0);
        reset = 1'b1;
        #1;
        chk("in_ready after release", in_ready, 1);

        run_one("fma basic",     4'h7, 16'h3F80, 16'h4000, 16'h40A0, 16'h40E0, 4'h0);
        run_one("fma subnormal", 4'h7, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 4'h0);
        run_one("fma inf",       4'h7, 16'h7F80, 16'h3F80, 16'h4040, 16'h7F80, 4'h0);
        run_one("mul inf*0",     4'h2, 16'h7F80, 16'h0000, 16'h1234, 16'h7FC0, 4'b1000);
        run_one("mul overflow",  4'h2, 16'h7F7F, 16'h4000, 16'h0000, 16'h7F80, 4'b0101);
        run_one("bad opcode",    4'h5, 16'h3F80, 16'h3F80, 16'h3F80, 16'h7FC0, 4'b1000);
        run_one("add",           4'h0, 16'h3F80, 16'h4000, 16'h0000, 16'h4040, 4'h0);
        run_one("sub",           4'h1, 16'h3F80, 16'h4000, 16'h0000, 16'hBF80, 4'h0);
        run_one("sub to zero",   4'h1, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 4'h0);
        run_one("neg zeros",     4'h0, 16'h8000, 16'h8000, 16'h0000, 16'h8000, 4'h0);
        run_one("tie to even",   4'h0, 16'h3F80, 16'h3B80, 16'h0000, 16'h3F80, 4'b0001);
        run_one("tie round up",  4'h0, 16'h3F81, 16'h3B80, 16'h0000, 16'h3F82, 4'b0001);
        run_one("underflow",     4'h2, 16'h0080, 16'h3F00, 16'h0000, 16'h0000, 4'b0011);
        run_one("neg underflow", 4'h2, 16'h8080, 16'h3F00, 16'h0000, 16'h8000, 4'b0011);
        run_one("mul neg",       4'h2, 16'hC000, 16'h4040, 16'h0000, 16'hC0C0, 4'h0);
        run_one("snan",          4'h0, 16'h7F81, 16'h3F80, 16'h0000, 16'h7FC0, 4'b1000);
        run_one("qnan",          4'h0, 16'h7FC1, 16'h3F80, 16'h0000, 16'h7FC0, 4'h0);
        run_one("inf minus inf", 4'h0, 16'h7F80, 16'hFF80, 16'h0000, 16'h7FC0, 4'b1000);
        run_one("fms zero",      4'h8, 16'h4000, 16'h4000, 16'h4080, 16'h0000, 4'h0);
        run_one("fma one round", 4'h7, 16'h3F81, 16'h3F81, 16'hBF81, 16'h3C01, 4'h0);

        // Back-to-back issue
        drive(4'h7, 16'h3F80, 16'h4000, 16'h40A0);
        @(negedge clk);
        drive(4'h7, 16'h4080, 16'h4000, 16'h40C0);
        @(negedge clk);
        idle_inputs();
        chk("b2b early valid", out_valid, 0);
        @(negedge clk);
        chk("b2b first valid", out_valid, 1);
        chk("b2b first result", result, 16'h40E0);
        @(negedge clk);
        chk("b2b second valid", out_valid, 1);
        chk("b2b second result", result, 16'h4160);
        @(negedge clk);
        chk("b2b drained valid", out_valid, 0);
        chk("idle result zero", result, 16'h0000);

        // Backpressure: four adds, consumer stalled for five cycles
        bp_exp[0] = 16'h4000;
        bp_exp[1] = 16'h4040;
        bp_exp[2] = 16'h4080;
        bp_exp[3] = 16'h40A0;
        out_ready = 1'b0;
        drive(4'h0, 16'h3F80, 16'h3F80, 16'h0);
        chk("bp in_ready r1", in_ready, 1);
        @(negedge clk);
        drive(4'h0, 16'h4000, 16'h3F80, 16'h0);
        chk("bp in_ready r2", in_ready, 1);
        @(negedge clk);
        drive(4'h0, 16'h4040, 16'h3F80, 16'h0);
        chk("bp in_ready r3", in_ready, 1);
        @(negedge clk);
        drive(4'h0, 16'h4080, 16'h3F80, 16'h0);
        chk("bp full in_ready", in_ready, 0);
        chk("bp head valid", out_valid, 1);
        chk("bp head result", result, bp_exp[0]);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp hold result", result, bp_exp[0]);
            chk("bp hold in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        got = 1;
        for (int i = 0; i < 20 && got < 4; i++) begin
            @(negedge clk);
            idle_inputs();
            if (out_valid) begin
                chk("bp order", result, bp_exp[got]);
                got++;
            end
        end
        chk("bp delivered", got, 4);
        @(negedge clk);
        chk("bp no duplicate", out_valid, 0);

        // Reset with two requests in flight
        drive(4'h7, 16'h3F80, 16'h4000, 16'h40A0);
        @(negedge clk);
        drive(4'h7, 16'h4080, 16'h4000, 16'h40C0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        chk("pre-reset valid", out_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("async reset valid", out_valid, 0);
        chk("async reset result", result, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_one("post reset", 4'h0, 16'h4000, 16'h4000, 16'h0000, 16'h4080, 4'h0);
        chk("post reset quiet", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bf16_fma_pipe.md
BF16_FMA_PIPE -- requirements
Module: bf16_fma_pipe

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low; 0 clears all state immediately.
REQ-003 SHALL have ports: in_valid  in  1  request present; in_ready  out  1  request accepted when in_valid&in_ready at a clk edge.
REQ-004 SHALL have ports: operand_a, operand_b, operand_c  in  16 each  bf16 operands, sampled on accept.
REQ-005 SHALL have ports: operation  in  4  opcode, sampled on accept.
REQ-006 SHALL have ports: out_valid  out  1  result present; out_ready  in  1  consumer accepts when out_valid&out_ready.
REQ-007 SHALL have ports: result  out  16  bf16 result; fpcsr  out  4  flags {invalid, overflow, underflow, inexact} (bit 3..0).

Function
REQ-008 SHALL decode operation: 4'h0 a+b; 4'h1 a-b; 4'h2 a*b; 4'h7 a*b+c; 4'h8 a*b-c; any other code -> result 16'h7FC0, fpcsr 4'b1000.
REQ-009 SHALL compute ops 4'h7/4'h8 as fused: exact a*b±c, one rounding.
REQ-010 SHALL round round-to-nearest-even; inexact set when any discarded bit is nonzero.
REQ-011 SHALL treat subnormal inputs (exp 0, mant≠0) as signed zero; no flag raised for input flush.
REQ-012 SHALL flush results below 2^-126 after rounding to signed zero, setting underflow and inexact.
REQ-013 SHALL produce signed infinity on overflow (exp>254 after rounding), setting overflow and inexact.
REQ-014 SHALL output 16'h7FC0 for any NaN input; invalid set only for signaling NaN (exp 255, mant≠0, mant[6]=0).
REQ-015 SHALL output 16'h7FC0 with invalid for inf*0 and for inf+(-inf) in the effective addition.
REQ-016 SHALL return +0 for an exact zero sum of opposite-signed operands; -0 only when both addends are -0.
REQ-017 SHALL be a 3-stage pipeline (S1 unpack/multiply, S2 align/add, S3 normalize/round/pack); out_valid rises exactly 3 cycles after accept with no backpressure.
REQ-018 SHALL sustain one accept per cycle while out_ready=1.
REQ-019 SHALL stall all stages when out_valid=1 and out_ready=0; in_ready = !out_valid | out_ready; bubbles do not collapse.
REQ-020 SHALL hold result and fpcsr stable while out_valid=1 and out_ready=0.
REQ-021 SHALL return results in acceptance order, never drop or duplicate one.
REQ-022 SHALL ignore operand/operation values when not accepted.
REQ-023 SHALL drive result and fpcsr to 0 when out_valid=0.

Reset
REQ-024 SHALL on reset=0 clear all stage valids, out_valid=0, result=16'h0000, fpcsr=4'h0; in_ready=1 once reset=1.
REQ-025 SHALL discard all in-flight requests when reset asserts mid-operation; none appear after release.
REQ-026 SHALL accept a request on the first clk edge after reset release.

Verification
REQ-027 SHALL cover FMA op 4'h7: a=16'h3F80, b=16'h4000, c=16'h40A0 -> result 16'h40E0, fpcsr 4'h0, out_valid 3 cycles after accept.
REQ-028 SHALL cover back-to-back: the above then a=16'h4080, b=16'h4000, c=16'h40C0 op 4'h7 on consecutive cycles -> 16'h40E0 then 16'h4160 on consecutive cycles.
REQ-029 SHALL cover subnormals: a=b=c=16'h0001 op 4'h7 -> 16'h0000, fpcsr 4'h0; inf: a=16'h7F80, b=16'h3F80, c=16'h4040 -> 16'h7F80, fpcsr 4'h0.
REQ-030 SHALL cover exceptions: a=16'h7F80, b=16'h0000 op 4'h2 -> 16'h7FC0, fpcsr 4'b1000; a=16'h7F7F, b=16'h4000 op 4'h2 -> 16'h7F80, fpcsr 4'b0101; op 4'h5 -> 16'h7FC0, fpcsr 4'b1000.
REQ-031 SHALL cover backpressure: 4 requests issued, out_ready held 0 for 5 cycles -> in_ready=0 once pipeline full, first result held stable, all 4 delivered in order after out_ready=1.
REQ-032 SHALL cover reset with 2 requests in flight -> out_valid=0 immediately, no stale result after release.
